td4_core_gen: RTL and testbench
===============================

Name: td4_core_gen

Overview:
- Parametrised successor to the 4-bit TD4 CPU core; data width and PC width are generics.
- Adds an instruction-fetch handshake with external instruction memory or test harness, plus a HALT state.
- Instruction words come from a tile input or ROM wrapper through a valid/request handshake.
- Exposes registers A/B, carry, PC and the output port for observation by the top-level tile.

Parameters:
- DATA_W, 4, width of A, B, immediate, in_port, out_port (legal 4..16).
- PC_W, 4, program counter width (legal 2..DATA_W); jump target = immediate[PC_W-1:0].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- ena  in  1  0 freezes all state (FSM, PC, registers, carry, out_port)
- fetch_req  out  1  high while in FETCH
- pc_o  out  PC_W  address of instruction being fetched
- instr_valid  in  1  instruction word valid; sampled only while fetch_req=1
- opcode  in  4  instruction opcode
- immediate  in  DATA_W  instruction immediate
- in_port  in  DATA_W  general input port
- out_port  out  DATA_W  registered output port
- reg_a_o  out  DATA_W  register A
- reg_b_o  out  DATA_W  register B
- carry_o  out  1  carry flag
- halted_o  out  1  core in HALT

Behaviour:
- Reset (async, rst_n=0): FSM=FETCH; PC, A, B, carry, out_port, IR=0; halted_o=0; fetch_req=1 after reset release.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: fetch_req=1. On instr_valid=1 && ena=1, latch {opcode, immediate} into IR and go to EXEC. Otherwise stay.
  - EXEC: execute IR in one cycle, then go to FETCH, or to HALT for the HALT opcode.
  - HALT: stay until reset. fetch_req=0, halted_o=1, no state changes.
- Throughput: 2 cycles per instruction minimum; each extra cycle of instr_valid=0 adds one cycle.
- Each EXEC commits the new register and carry values, and PC = PC+1 unless the instruction jumps. PC wraps modulo 2^PC_W.
- ALU: sum = src + imm, computed in DATA_W+1 bits. Result = low DATA_W bits; carry = bit DATA_W. MOV and IN use an imm of 0, so carry=0.
- Carry is written on every executed instruction: ADD writes its carry-out; all other instructions write 0.
- Opcodes (DATA_W-wide Im):
  - 0000 ADD A,Im; 0101 ADD B,Im
  - 0001 MOV A,B; 0100 MOV B,A
  - 0011 MOV A,Im; 0111 MOV B,Im
  - 0010 IN A; 0110 IN B (in_port sampled in the EXEC cycle)
  - 1001 OUT B; 1011 OUT Im (out_port updated at the end of EXEC)
  - 1110 JNC Im: jump if carry (before this instruction) = 0. Carry is then cleared.
  - 1111 JMP Im
  - 1101 HALT: PC not incremented; carry cleared.
  - 1000, 1010, 1100: NOP (carry cleared, PC+1), unless TD4_EXT_OPS_EN is defined.
- Jump target: immediate[PC_W-1:0]; upper immediate bits ignored.
- ena=0 in any state holds everything. An instr_valid pulse while ena=0 is ignored.
- instr_valid outside FETCH is ignored.
- rst_n low mid-EXEC or in HALT: immediate return to reset values; no partial commit.

Optional Feature:
- Macro TD4_EXT_OPS_EN, defined:
  - 1000 = SUB A,Im. A = A - Im mod 2^DATA_W; carry = 1 on borrow (A < Im).
  - 1010 = ADD A,B. A = A + B; carry = carry-out.
  - 1100 = OUT A.
- Undefined: these three opcodes are NOPs, as listed above.

Decomposition:
- Shared package td4_pkg holds:
  - opcode localparams (OP_ADD_A, OP_MOV_AB, ..., OP_HALT, OP_SUB_A, OP_ADD_AB, OP_OUT_A);
  - FSM state enum typedef (ST_FETCH, ST_EXEC, ST_HALT).
- One natural sub-module: td4_alu, combinational, parametrised by DATA_W.
  - Inputs: operand_a, operand_b, sub.
  - Outputs: result, carry.
  - Instantiated once; the core handles source and destination muxing.

Test Plan (DATA_W=4, PC_W=4):
- Reset, then instr_valid held 1: fetch_req=1, pc_o=0. MOV A,3 then ADD A,14 -> A=1, carry=1 after the second EXEC; pc_o=2.
- Carry=1, then JNC 5 -> PC=PC+1 and carry=0. A following JNC 9 -> pc_o=9.
- in_port=4'hA, IN B, OUT B -> out_port=A in the cycle after that EXEC. OUT 7 -> out_port=7.
- PC=15, NOP -> pc_o=0 (wrap). instr_valid low for 3 cycles in FETCH -> PC and registers unchanged, fetch_req stays 1.
- HALT at PC=6 -> halted_o=1, fetch_req=0, pc_o stays 6 under further instr_valid. rst_n pulse -> PC=0, halted_o=0.
- With TD4_EXT_OPS_EN: A=2, SUB A,3 -> A=15, carry=1. Without the macro: the same opcode leaves A=2, carry=0, PC+1.

Source files
------------

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - opcodes and FSM state type shared by the td4 core files
package td4_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_SUB_A  = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_ADD_AB = 4'b1010;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_OUT_A  = 4'b1100;
    localparam logic [3:0] OP_HALT   = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/td4_alu.sv
// rtl/td4_alu.sv - combinational add/subtract; carry is carry-out on add, borrow on subtract
module td4_alu #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // One extra bit: its top bit is the carry-out, or the borrow when a < b
    always_comb begin
        if (sub) begin
            wide = {1'b0, operand_a} - {1'b0, operand_b};
        end else begin
            wide = {1'b0, operand_a} + {1'b0, operand_b};
        end
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];

endmodule

// File: rtl/td4_core_gen.sv
// rtl/td4_core_gen.sv - parametrised TD4 core with fetch handshake and HALT
// Optional opcodes SUB A,Im / ADD A,B / OUT A are enabled by TD4_EXT_OPS_EN.
module td4_core_gen
    import td4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic              fetch_req,
    output logic [PC_W-1:0]   pc_o,
    input  logic              instr_valid,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] reg_a_o,
    output logic [DATA_W-1:0] reg_b_o,
    output logic              carry_o,
    output logic              halted_o
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              carry_q, carry_d;
    logic [3:0]        ir_op_q, ir_op_d;
    logic [DATA_W-1:0] ir_imm_q, ir_imm_d;

    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic              alu_sub, alu_carry;

    td4_alu #(.DATA_W(DATA_W)) u_alu (
        .operand_a (alu_a),
        .operand_b (alu_b),
        .sub       (alu_sub),
        .result    (alu_res),
        .carry     (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        carry_d  = carry_q;
        ir_op_d  = ir_op_q;
        ir_imm_d = ir_imm_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_sub  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (ena && instr_valid) begin
                    ir_op_d  = opcode;
                    ir_imm_d = immediate;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ena) begin
                    pc_d    = pc_q + PC_W'(1);
                    carry_d = 1'b0;
                    state_d = ST_FETCH;
                    case (ir_op_q)
                        OP_ADD_A: begin
                            alu_a   = a_q;
                            alu_b   = ir_imm_q;
                            a_d     = alu_res;
                            carry_d = alu_carry;
                        end
                        OP_ADD_B: begin
                            alu_a   = b_q;
                            alu_b   = ir_imm_q;
                            b_d     = alu_res;
                            carry_d = alu_carry;
                        end
                        OP_MOV_AB: a_d   = b_q;
                        OP_MOV_BA: b_d   = a_q;
                        OP_MOV_AI: a_d   = ir_imm_q;
                        OP_MOV_BI: b_d   = ir_imm_q;
                        OP_IN_A:   a_d   = in_port;
                        OP_IN_B:   b_d   = in_port;
                        OP_OUT_B:  out_d = b_q;
                        OP_OUT_I:  out_d = ir_imm_q;
                        OP_JNC: begin
                            // Tests the carry left by the previous instruction
                            if (!carry_q) pc_d = ir_imm_q[PC_W-1:0];
                        end
                        OP_JMP:    pc_d  = ir_imm_q[PC_W-1:0];
                        OP_HALT: begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
`ifdef TD4_EXT_OPS_EN
                        OP_SUB_A: begin
                            alu_a   = a_q;
                            alu_b   = ir_imm_q;
                            alu_sub = 1'b1;
                            a_d     = alu_res;
                            carry_d = alu_carry;
                        end
                        OP_ADD_AB: begin
                            alu_a   = a_q;
                            alu_b   = b_q;
                            a_d     = alu_res;
                            carry_d = alu_carry;
                        end
                        OP_OUT_A:  out_d = a_q;
`endif
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            ir_op_q  <= '0;
            ir_imm_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            ir_op_q  <= ir_op_d;
            ir_imm_q <= ir_imm_d;
        end
    end

    assign fetch_req = (state_q == ST_FETCH);
    assign halted_o  = (state_q == ST_HALT);
    assign pc_o      = pc_q;
    assign reg_a_o   = a_q;
    assign reg_b_o   = b_q;
    assign carry_o   = carry_q;
    assign out_port  = out_q;

endmodule

// File: tb/tb_td4_core_gen.sv
// tb/tb_td4_core_gen.sv - randomized scoreboard bench for td4_core_gen
module tb_td4_core_gen;

    localparam int DATA_W = 4;
    localparam int PC_W   = 4;
    localparam int DMOD   = 1 << DATA_W;
    localparam int PMOD   = 1 << PC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              fetch_req;
    logic [PC_W-1:0]   pc_o;
    logic              instr_valid = 1'b0;
    logic [3:0]        opcode = '0;
    logic [DATA_W-1:0] immediate = '0;
    logic [DATA_W-1:0] in_port = '0;
    logic [DATA_W-1:0] out_port;
    logic [DATA_W-1:0] reg_a_o;
    logic [DATA_W-1:0] reg_b_o;
    logic              carry_o;
    logic              halted_o;

    td4_core_gen #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .fetch_req   (fetch_req),
        .pc_o        (pc_o),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .immediate   (immediate),
        .in_port     (in_port),
        .out_port    (out_port),
        .reg_a_o     (reg_a_o),
        .reg_b_o     (reg_b_o),
        .carry_o     (carry_o),
        .halted_o    (halted_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int a;
        int b;
        int c;
        int out;
        int h;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int m_pc, m_a, m_b, m_c, m_out, m_h;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_h = 0;
    endfunction

    // Instruction-level reference: one call = one executed instruction
    function automatic void model_step(int op, int imm, int inp);
        int s;
        int next_pc;
        int next_c;
        next_pc = (m_pc + 1) % PMOD;
        next_c  = 0;
        case (op)
            0:  begin s = m_a + imm; m_a = s % DMOD; next_c = (s >= DMOD); end
            5:  begin s = m_b + imm; m_b = s % DMOD; next_c = (s >= DMOD); end
            1:  m_a = m_b;
            4:  m_b = m_a;
            3:  m_a = imm;
            7:  m_b = imm;
            2:  m_a = inp;
            6:  m_b = inp;
            9:  m_out = m_b;
            11: m_out = imm;
            14: if (m_c == 0) next_pc = imm % PMOD;
            15: next_pc = imm % PMOD;
            13: begin next_pc = m_pc; m_h = 1; end
`ifdef TD4_EXT_OPS_EN
            8:  begin next_c = (m_a < imm); m_a = (m_a - imm + DMOD) % DMOD; end
            10: begin s = m_a + m_b; m_a = s % DMOD; next_c = (s >= DMOD); end
            12: m_out = m_a;
`endif
            default: ;
        endcase
        m_pc = next_pc;
        m_c  = next_c;
    endfunction

    // Monitor: an accepted fetch is followed by a commit on the next enabled edge
    logic fr_n;
    bit   pending = 1'b0;
    always @(negedge clk) fr_n = fetch_req;

    always @(posedge clk) begin
        bit v_en, v_acc;
        exp_t e;
        v_en  = ena;
        v_acc = rst_n && fr_n && instr_valid && ena;
        #1;
        if (!rst_n) begin
            pending = 1'b0;
        end else if (pending && v_en) begin
            pending = 1'b0;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("mon_pc", int'(pc_o), e.pc);
                chk("mon_a", int'(reg_a_o), e.a);
                chk("mon_b", int'(reg_b_o), e.b);
                chk("mon_carry", int'(carry_o), e.c);
                chk("mon_out", int'(out_port), e.out);
                chk("mon_halted", int'(halted_o), e.h);
                chk("mon_fetch_req", int'(fetch_req), 1 - e.h);
            end
        end else if (v_acc) begin
            pending = 1'b1;
            chk("exec_fetch_req_low", int'(fetch_req), 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        ena = 1'b1;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(int op, int imm, int inp, int gaps, bit rnd_ena);
        bit acc;
        bit done;
        exp_t e;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            opcode = 4'($urandom);
            immediate = DATA_W'($urandom);
            ena = 1'b1;
            #1;
            chk("gap_fetch_req", int'(fetch_req), 1);
            chk("gap_pc", int'(pc_o), m_pc);
        end
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            opcode = 4'(op);
            immediate = DATA_W'(imm);
            in_port = DATA_W'(inp);
            instr_valid = 1'b1;
            ena = rnd_ena ? ($urandom % 5 != 0) : 1'b1;
            if (fetch_req && ena) begin
                acc = 1'b1;
                model_step(op, imm, inp);
                e.pc = m_pc; e.a = m_a; e.b = m_b; e.c = m_c; e.out = m_out; e.h = m_h;
                sb.push_back(e);
            end
            @(posedge clk);
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            instr_valid = 1'($urandom);
            opcode = 4'($urandom);
            immediate = DATA_W'($urandom);
            ena = rnd_ena ? ($urandom % 4 != 0) : 1'b1;
            @(posedge clk);
            done = ena;
        end
        if (!done) chk("commit_timeout", 0, 1);
    endtask

    initial begin
        int op;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fetch_req", int'(fetch_req), 0 + 1);
        chk("rst_pc", int'(pc_o), 0);
        chk("rst_a", int'(reg_a_o), 0);
        chk("rst_carry", int'(carry_o), 0);
        chk("rst_halted", int'(halted_o), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_fetch_req", int'(fetch_req), 1);

        issue(3, 3, 0, 0, 0);
        issue(0, 14, 0, 0, 0);
        #2;
        chk("add_a", int'(reg_a_o), 1);
        chk("add_carry", int'(carry_o), 1);
        chk("add_pc", int'(pc_o), 2);
        issue(14, 5, 0, 0, 0);
        #2;
        chk("jnc_taken_not_pc", int'(pc_o), 3);
        chk("jnc_carry_clr", int'(carry_o), 0);
        issue(14, 9, 0, 0, 0);
        #2;
        chk("jnc_jump_pc", int'(pc_o), 9);
        issue(6, 0, 4'hA, 0, 0);
        issue(9, 0, 0, 0, 0);
        #2;
        chk("out_b", int'(out_port), 10);
        issue(11, 7, 0, 0, 0);
        #2;
        chk("out_imm", int'(out_port), 7);
        issue(15, 15, 0, 0, 0);
        issue(3, 0, 0, 3, 0);
        #2;
        chk("pc_wrap", int'(pc_o), 0);
        issue(3, 2, 0, 0, 0);
        issue(8, 3, 0, 0, 0);
        #2;
`ifdef TD4_EXT_OPS_EN
        chk("sub_a", int'(reg_a_o), 15);
        chk("sub_borrow", int'(carry_o), 1);
`else
        chk("nop8_a", int'(reg_a_o), 2);
        chk("nop8_carry", int'(carry_o), 0);
`endif
        chk("op8_pc", int'(pc_o), 2);

        for (int i = 0; i < 200; i++) begin
            do op = int'($urandom % 16); while (op == 13);
            issue(op, int'($urandom % DMOD), int'($urandom % DMOD), int'($urandom % 3), 1);
        end

        issue(15, 6, 0, 0, 0);
        issue(13, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            opcode = 4'($urandom);
            immediate = DATA_W'($urandom);
            ena = 1'($urandom);
            #1;
            chk("halt_pc", int'(pc_o), 6);
            chk("halt_fetch_req", int'(fetch_req), 0);
            chk("halt_flag", int'(halted_o), 1);
        end
        do_reset();
        #1;
        chk("post_halt_rst_pc", int'(pc_o), 0);
        chk("post_halt_rst_halted", int'(halted_o), 0);

        issue(3, 9, 0, 0, 0);
        @(negedge clk);
        opcode = 4'd3;
        immediate = DATA_W'(5);
        instr_valid = 1'b1;
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_exec_rst_a", int'(reg_a_o), 0);
        chk("mid_exec_rst_pc", int'(pc_o), 0);
        chk("mid_exec_rst_fetch_req", int'(fetch_req), 1);
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        #1;
        chk("idle_a", int'(reg_a_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
